// File: rtl/tx_word_serializer.sv
// Serializes parallel words (or PRBS7/PRBS15/idle zeros) into one bit per clock for the FIR driver.
// Latency: accepted word reaches dout within W+1 cycles (2 cycles when accepted just before a word boundary).
// Backpressure: one-entry holding buffer; din_ready drops while it is full and rises once it drains at a DATA boundary.
module tx_word_serializer #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [1:0]   mode,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         clr_underrun,
  output logic         dout,
  output logic         word_start,
  output logic         underrun
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PRBS = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           prbs15_q, prbs15_d;   // 1: PRBS15 polynomial selected, 0: PRBS7
  logic           first_q;              // first cycle after reset release acts as a boundary
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hold_vld_q, hold_vld_d;
  logic [W-1:0]   hold_data_q, hold_data_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [6:0]     l7_q, l7_d;
  logic [14:0]    l15_q, l15_d;
  logic           dout_d, ws_d, ur_d, rdy_d;

  logic           boundary;
  logic           xfer;
  logic           load;
  logic           reseed;
  logic [6:0]     l7_cur;
  logic [14:0]    l15_cur;
  logic           fb7, fb15;
  logic [W-1:0]   sh_src;

  // Next-state, buffer, LFSR and registered-output decode; mode only matters at boundaries.
  always_comb begin
    boundary    = first_q | (cnt_q == CW'(W - 1));
    xfer        = din_valid & din_ready;
    state_d     = state_q;
    prbs15_d    = prbs15_q;
    cnt_d       = boundary ? '0 : cnt_q + CW'(1);
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    sh_d        = sh_q;
    l7_d        = l7_q;
    l15_d       = l15_q;
    dout_d      = 1'b0;
    ws_d        = boundary;
    ur_d        = underrun;
    sh_src      = sh_q;

    if (boundary) begin
      case (mode)
        2'd0:    state_d = S_IDLE;
        2'd1:    state_d = S_DATA;
        2'd2: begin
          state_d  = S_PRBS;
          prbs15_d = 1'b0;
        end
        default: begin
          state_d  = S_PRBS;
          prbs15_d = 1'b1;
        end
      endcase
    end

    // Entering PRBS, or changing polynomial, restarts the sequence from all-ones.
    reseed  = boundary & (state_d == S_PRBS) &
              ((state_q != S_PRBS) | (prbs15_d != prbs15_q));
    l7_cur  = (reseed & ~prbs15_d) ? 7'h7F : l7_q;
    l15_cur = (reseed &  prbs15_d) ? 15'h7FFF : l15_q;
    fb7     = l7_cur[6] ^ l7_cur[5];
    fb15    = l15_cur[14] ^ l15_cur[13];

    load = boundary & (state_d == S_DATA) & hold_vld_q;

    if (state_d == S_PRBS) begin
      // Shift register is bypassed; only the selected LFSR advances.
      if (prbs15_d) begin
        dout_d = fb15;
        l15_d  = {l15_cur[13:0], fb15};
      end else begin
        dout_d = fb7;
        l7_d   = {l7_cur[5:0], fb7};
      end
    end else begin
      if (boundary) begin
        sh_src = load ? hold_data_q : '0;
      end
      dout_d = MSB_FIRST ? sh_src[W-1] : sh_src[0];
      sh_d   = MSB_FIRST ? (sh_src << 1) : (sh_src >> 1);
    end

    // Set beats clear when both happen on the same edge.
    if (clr_underrun) begin
      ur_d = 1'b0;
    end
    if (boundary & (state_d == S_DATA) & ~hold_vld_q) begin
      ur_d = 1'b1;
    end

    // A load frees the buffer; a same-edge transfer refills it with the new word.
    if (load) begin
      hold_vld_d = 1'b0;
    end
    if (xfer) begin
      hold_vld_d  = 1'b1;
      hold_data_d = din;
    end
    rdy_d = ~hold_vld_d;
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      prbs15_q    <= 1'b0;
      first_q     <= 1'b1;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      sh_q        <= '0;
      l7_q        <= 7'h7F;
      l15_q       <= 15'h7FFF;
      dout        <= 1'b0;
      word_start  <= 1'b0;
      underrun    <= 1'b0;
      din_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prbs15_q    <= prbs15_d;
      first_q     <= 1'b0;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      sh_q        <= sh_d;
      l7_q        <= l7_d;
      l15_q       <= l15_d;
      dout        <= dout_d;
      word_start  <= ws_d;
      underrun    <= ur_d;
      din_ready   <= rdy_d;
    end
  end

endmodule
